// File: rtl/brcsr_iq_slot_arbiter.sv
// brcsr_iq_slot_arbiter
// Allocation controller for the branch/CSR issue-queue free-slot list.
// Two dispatch lanes share the list's single pop port under round-robin
// priority. Released slots are pushed back into the list. The list is
// cleaned on reset and on pipeline flush.
// Optional consistency checking is enabled by defining BRCSR_IQ_ARB_CHECK_EN.
// When that macro is not defined, Err is tied low.
module brcsr_iq_slot_arbiter #(
    parameter int SLOTW = 4,
    parameter int SLOTN = 4
) (
    input  logic             Clk,
    input  logic             Rest,
    input  logic             Req0,
    input  logic             Req1,
    output logic             Gnt0,
    output logic             Gnt1,
    output logic [SLOTW-1:0] GntSlot,
    input  logic             RelValid,
    input  logic [SLOTW-1:0] RelSlot,
    input  logic             Flush,
    output logic             Ready,
    output logic             Err,
    output logic             QRable,
    output logic             QWable,
    output logic [SLOTW-1:0] QDin,
    output logic             QClean,
    input  logic [SLOTW-1:0] QPreOut,
    input  logic             QEmpty
);

    localparam int CW = $clog2(SLOTN + 1);
    localparam logic [CW-1:0] FULL = CW'(SLOTN);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_SETTLE = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_last_gnt;   // 1 = lane 1 won last, so lane 0 wins the next contest
    logic [CW-1:0]   r_free_cnt;

    logic w_run;
    logic w_gnt0;
    logic w_gnt1;
    logic w_grant;
    logic w_push;

    // Grants and pushes happen only in RUN, outside reset and flush cycles.
    // A release never bypasses an empty list: grants depend on QEmpty alone.
    assign w_run   = (r_state == S_RUN) && !Rest && !Flush;
    assign w_gnt0  = w_run && !QEmpty && Req0 && (!Req1 || r_last_gnt);
    assign w_gnt1  = w_run && !QEmpty && Req1 && (!Req0 || !r_last_gnt);
    assign w_grant = w_gnt0 || w_gnt1;
    // The credit guard always suppresses a push into a list that is already full.
    assign w_push  = w_run && RelValid && (r_free_cnt != FULL);

    assign Gnt0    = w_gnt0;
    assign Gnt1    = w_gnt1;
    assign GntSlot = QPreOut;
    assign QRable  = w_grant;
    assign QWable  = w_push;
    assign QDin    = RelSlot;
    assign QClean  = (r_state == S_INIT) && !Rest;
    assign Ready   = (r_state == S_RUN) && !Rest;

    // State sequencing, round-robin pointer, and free-slot credit tracking.
    always_ff @(posedge Clk) begin
        if (Rest) begin
            r_state    <= S_INIT;
            r_last_gnt <= 1'b1;
            r_free_cnt <= FULL;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_free_cnt <= FULL;
                    r_state    <= Flush ? S_INIT : S_SETTLE;
                end
                S_SETTLE: begin
                    r_state <= Flush ? S_INIT : S_RUN;
                end
                S_RUN: begin
                    if (Flush) begin
                        r_state <= S_INIT;
                    end
                    if (w_gnt0) begin
                        r_last_gnt <= 1'b0;
                    end else if (w_gnt1) begin
                        r_last_gnt <= 1'b1;
                    end
                    if (w_grant && !w_push && (r_free_cnt != '0)) begin
                        r_free_cnt <= r_free_cnt - CW'(1);
                    end else if (w_push && !w_grant) begin
                        r_free_cnt <= r_free_cnt + CW'(1);
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

`ifdef BRCSR_IQ_ARB_CHECK_EN
    logic r_err;
    logic w_ovf;
    logic w_mis;

    // The overflow test uses w_run, the same gate as w_push, so a release
    // during a flush is simply dropped and is never flagged.
    assign w_ovf = w_run && RelValid && (r_free_cnt == FULL);
    // The empty-list test applies in every RUN cycle outside reset, flush included.
    assign w_mis = (r_state == S_RUN) && !Rest && (QEmpty != (r_free_cnt == '0));

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (Rest) begin
            r_err <= 1'b0;
        end else if (w_ovf || w_mis) begin
            r_err <= 1'b1;
        end
    end

    assign Err = r_err;
`else
    assign Err = 1'b0;
`endif

endmodule

// File: doc/brcsr_iq_slot_arbiter.md
# brcsr_iq_slot_arbiter

Allocation controller for the branch/CSR issue-queue free-slot list (the 4-entry slot-index queue holding 0, 4, 8, 12 after clean). It shares the single pop port between two dispatch lanes with round-robin priority and writes slots released by issue back into the list. It also sequences the list's clean on reset and pipeline flush. The block sits between dispatch and the slot-list queue and drives all of that queue's control inputs.

## Interface
- `SLOTW`, 4: slot-index width.
- `SLOTN`, 4: number of slots in the list; credit counter range 0..SLOTN.
- `Clk` in 1: single clock, all state updates on rising edge.
- `Rest` in 1: synchronous, active-high reset.
- `Req0`, `Req1` in 1: dispatch lane allocation requests.
- `Gnt0`, `Gnt1` out 1: lane grant, combinational, at most one high per cycle.
- `GntSlot` out SLOTW: granted slot index, valid when `Gnt0|Gnt1`.
- `RelValid` in 1: issue releases a slot this cycle.
- `RelSlot` in SLOTW: released slot index.
- `Flush` in 1: pipeline flush; all slots return to the list.
- `Ready` out 1: high only in RUN.
- `Err` out 1: sticky consistency error (see Configuration).
- `QRable` out 1: pop strobe to the slot list; equals `Gnt0|Gnt1`.
- `QWable` out 1: push strobe to the slot list.
- `QDin` out SLOTW: push data; equals `RelSlot`.
- `QClean` out 1: clean strobe to the slot list.
- `QPreOut` in SLOTW: slot-list head, combinational.
- `QEmpty` in 1: slot list empty.

## Operation
- FSM states: INIT, SETTLE, RUN.
  - `Rest`: next state is INIT.
  - INIT goes to SETTLE unconditionally.
  - SETTLE goes to RUN unconditionally.
  - RUN goes to INIT when `Flush`=1.
  - `Flush` in INIT or SETTLE restarts at INIT.
- INIT: `QClean`=1 for exactly that cycle. `FreeCnt` loads SLOTN. No grants and no pushes.
- SETTLE: no grants and no pushes. Gives the list one cycle to present the cleaned head.
- RUN, grant logic (grant only when `Flush`=0 and `QEmpty`=0):
  - One requester: that lane is granted.
  - Both requesters: the lane opposite `LastGnt` is granted.
  - `LastGnt` is updated on every grant and resets to 1, so lane 0 wins the first contest.
  - `GntSlot`=`QPreOut`, and the list pops at the same edge.
- RUN, release: when `Flush`=0 and `RelValid`=1, `QWable`=1. A grant and a release in the same cycle are both performed.
- `RelValid` outside RUN, or in the cycle `Flush`=1, is dropped. The clean restores every slot.
- `FreeCnt` (width clog2(SLOTN+1)):
  - −1 per grant, +1 per accepted release, net 0 when both occur in one cycle.
  - Reloads SLOTN in INIT.
  - Never wraps.
- Ungranted requests are not queued. A requester must hold `Req` until granted.

## Timing
- Reset values: state INIT, `Gnt0`=`Gnt1`=0, `QRable`=`QWable`=0, `QClean`=0 during the `Rest` cycle then 1 in INIT, `Ready`=0, `Err`=0, `LastGnt`=1, `FreeCnt`=SLOTN.
- After `Rest` falls at edge E: INIT in cycle E, SETTLE in E+1, RUN with first grant possible in E+2.
- Grant latency is zero: `Req` high with list non-empty gives `Gnt` in the same cycle. The head advances after the edge, so back-to-back grants receive consecutive slots.
- `Flush` in RUN at cycle N: no grant or push in N, INIT in N+1, SETTLE in N+2, RUN in N+3.
- Empty list: no grant. A same-cycle release does not bypass to a grant; it becomes grantable in the next cycle.

## Configuration
- `BRCSR_IQ_ARB_CHECK_EN` defined: RUN checks the following each cycle, and `Err` sets and holds until `Rest`.
  - `QEmpty` must equal (`FreeCnt`==0).
  - `RelValid` accepted with `FreeCnt`==SLOTN is an overflow.
  - On overflow the push is still suppressed.
- Not defined: `Err` is tied to 0. Overflowing releases are suppressed only by the `FreeCnt` guard, which is always present.

## Test plan
- Reset, then `Req0` held 5 cycles from RUN → `Gnt0` in 4 consecutive cycles with `GntSlot` 0, 4, 8, 12, then no grant in the 5th (empty); `FreeCnt` reaches 0.
- `Req0`=`Req1`=1 continuously → grants alternate lane0, lane1, lane0, lane1 with slots 0, 4, 8, 12.
- List empty, `RelSlot`=8 released → no grant that cycle, `Gnt` with `GntSlot`=8 the next cycle.
- After 2 grants, simultaneous grant plus release of 0 → both occur, `FreeCnt` unchanged at 2, and the released 0 appears after 12.
- `Flush` in RUN with `RelValid`=1 → no push, `QClean` pulses at N+1, `Ready` rises at N+3, next grant slot 0.
- With `BRCSR_IQ_ARB_CHECK_EN` defined, release while `FreeCnt`=4 → `Err`=1 sticky, `QWable`=0.
